// File: rtl/vedic_mac_acc.sv
// Streaming multiply-accumulate wrapper for a combinational 8x8 multiplier:
// registers operands, captures products, sums a frame and returns one result per frame.
module vedic_mac_acc #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_ovf
);

    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_e;

    state_e           state_q, state_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic [2:1]       vld_pipe_q, vld_pipe_d;
    logic [2:1]       lst_pipe_q, lst_pipe_d;
    logic [15:0]      prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             res_valid_q, res_valid_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_ovf_q, res_ovf_d;

    logic             hs;
    logic             frame_end;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready  = (state_q == ACC);
    assign hs        = in_valid & in_ready;
    assign frame_end = vld_pipe_q[2] & lst_pipe_q[2];
    // extra MSB of sum is the carry out of the accumulator
    assign sum       = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            vld_pipe_q  <= '0;
            lst_pipe_q  <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            vld_pipe_q  <= vld_pipe_d;
            lst_pipe_q  <= lst_pipe_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cnt_q   <= res_cnt_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (hs && in_last) state_d = DRAIN;
            DRAIN:   if (frame_end) state_d = HOLD;
            HOLD:    if (res_valid_q && res_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cnt_d   = res_cnt_q;
        res_ovf_d   = res_ovf_q;
        vld_pipe_d  = {vld_pipe_q[1], hs};
        lst_pipe_d  = {lst_pipe_q[1], hs & in_last};

        if (hs) begin
            mul_a_d = in_a;
            mul_b_d = in_b;
        end
        if (vld_pipe_q[1]) prod_d = mul_y;

        if (vld_pipe_q[2]) begin
            if (lst_pipe_q[2]) begin
                res_data_d  = sum[ACC_W-1:0];
                res_cnt_d   = cnt_inc;
                res_ovf_d   = ovf_q | sum[ACC_W];
                res_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_inc;
                ovf_d = ovf_q | sum[ACC_W];
            end
        end

        if (state_q == HOLD && res_valid_q && res_ready) res_valid_d = 1'b0;
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cnt   = res_cnt_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Scoreboard bench for vedic_mac_acc: a driver pushes whole-frame expectations computed
// with plain integer arithmetic; a monitor pops them whenever a result appears.
module tb_vedic_mac_acc;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    typedef struct {
        longint unsigned data;
        longint unsigned cnt;
        bit              ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0, in_b = '0;
    logic             in_last = 1'b0;
    logic [7:0]       mul_a, mul_b;
    logic [15:0]      mul_y;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_cnt;
    logic             res_ovf;

    int   total = 0;
    int   bad = 0;
    exp_t expq[$];
    bit   hold_low = 1'b0;
    bit   mon_en = 1'b0;

    longint unsigned fsum = 0;
    longint unsigned fcnt = 0;

    // behavioural stand-in for the combinational multiplier core
    assign mul_y = mul_a * mul_b;

    always #5 clk = ~clk;

    vedic_mac_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(mul_a), .mul_b(mul_b),
        .mul_y(mul_y), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cnt(res_cnt), .res_ovf(res_ovf)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // offer one pair; returns at E0+1 after the accepting edge
    task automatic send(input int a, input int b, input bit last);
        bit r;
        int guard;
        in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b); in_last = last;
        guard = 0;
        do begin
            r = in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!r && guard < 1000);
        if (!r) begin
            total++; bad++;
            $display("FAIL handshake_timeout at %0t", $time);
        end
        fsum += longint'(a) * longint'(b);
        fcnt++;
        if (last) begin
            expq.push_back('{fsum % (64'd1 << ACC_W), fcnt % (64'd1 << CNT_W), fsum >= (64'd1 << ACC_W)});
            fsum = 0; fcnt = 0;
        end
    endtask

    always begin
        @(posedge clk); #1;
        res_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // monitor: pops on each result rise, checks hold stability and release timing
    initial begin
        logic             pv, pr;
        logic [ACC_W-1:0] pd;
        logic [CNT_W-1:0] pc;
        logic             po;
        exp_t             e;
        pv = 1'b0; pr = 1'b0; pd = '0; pc = '0; po = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (res_valid && !pv) begin
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_result data=%0d", res_data);
                    end else begin
                        e = expq.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_cnt", res_cnt, e.cnt);
                        check("res_ovf", res_ovf, e.ovf);
                    end
                end
                if (res_valid && pv) begin
                    check("hold_data", res_data, pd);
                    check("hold_cnt", res_cnt, pc);
                    check("hold_ovf", res_ovf, po);
                end
                if (res_valid) check("in_ready_hold", in_ready, 0);
                if (pv && pr) begin
                    check("valid_drop", res_valid, 0);
                    check("in_ready_release", in_ready, 1);
                end
            end
            pv = res_valid && rst_n; pr = res_ready;
            pd = res_data; pc = res_cnt; po = res_ovf;
        end
    end

    initial begin
        int n;
        int guard;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_cnt", res_cnt, 0);
        check("rst_ovf", res_ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // T1: single term, 2-edge latency
        send(255, 255, 1);
        in_valid = 1'b0;
        check("t1_lat_e0", res_valid, 0);
        check("t1_drain", in_ready, 0);
        @(posedge clk); #1;
        check("t1_lat_e1", res_valid, 0);
        @(posedge clk); #1;
        check("t1_lat_e2", res_valid, 1);

        // T2: back-to-back terms
        send(3, 4, 0); send(5, 6, 0); send(7, 8, 1);
        in_valid = 1'b0;
        check("t2_drain", in_ready, 0);
        idle(2);

        // T3: 259 max terms, wrapping counter and accumulator
        for (int i = 0; i < 259; i++) send(255, 255, i == 258);
        send(2, 2, 1);
        idle(2);

        // T4: consumer stalls; in_valid pulses during hold are ignored
        guard = 0;
        while (res_valid || !in_ready) begin idle(1); if (++guard > 100) break; end
        hold_low = 1'b1;
        send(9, 9, 1);
        in_valid = 1'b0;
        idle(2);
        check("t4_valid", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_a = 8'd200; in_b = 8'd200; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        hold_low = 1'b0;

        // T5: gaps inside a frame
        idle($urandom_range(0, 3)); send(10, 10, 0);
        idle($urandom_range(1, 4)); send(20, 20, 1);
        idle(1);

        // T6: reset mid-frame discards partial sum
        guard = 0;
        while (res_valid || !in_ready) begin idle(1); if (++guard > 100) break; end
        send(100, 100, 0); send(100, 100, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        fsum = 0; fcnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t6_mul_a", mul_a, 0);
        check("t6_valid", res_valid, 0);
        check("t6_data", res_data, 0);
        check("t6_cnt", res_cnt, 0);
        check("t6_ovf", res_ovf, 0);
        check("t6_in_ready", in_ready, 1);
        send(1, 1, 1);

        // random frames
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                send($urandom_range(0, 255), $urandom_range(0, 255), i == n - 1);
            end
        end
        in_valid = 1'b0;

        guard = 0;
        while ((expq.size() != 0 || res_valid) && guard < 500) begin idle(1); guard++; end
        check("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
